aclk_ctrl_fsm: RTL and testbench

- Keypad-entry controller for the alarm clock. Sits directly upstream of the 4-digit key shift register.
- Watches the decoded key code and the 1 Hz tick.
- Generates one shift pulse per digit press, plus the load strobes that commit the entered time to either the alarm register or the current-time counter.
- Generates the display-select flags for the display mux.
- Abandons an entry after a keypad-idle timeout.

---
 rtl/aclk_pkg.sv | 29 ++
 rtl/aclk_timeout_cnt.sv | 39 +++
 rtl/aclk_ctrl_fsm.sv | 86 ++++++++
 tb/tb_aclk_ctrl_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad path: key codes, the
// controller state encoding and a digit test. Also used by the display mux
// and the key register.
package aclk_pkg;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  typedef logic [2:0] aclk_state_t;

  localparam aclk_state_t SHOW_TIME        = 3'd0;
  localparam aclk_state_t KEY_STORED       = 3'd1;
  localparam aclk_state_t KEY_WAITED       = 3'd2;
  localparam aclk_state_t KEY_ENTRY        = 3'd3;
  localparam aclk_state_t SHOW_ALARM       = 3'd4;
  localparam aclk_state_t SET_ALARM_TIME   = 3'd5;
  localparam aclk_state_t SET_CURRENT_TIME = 3'd6;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Codes C..E are not assigned to keys and count as "no key pressed".
  function automatic logic is_nokey(input logic [3:0] k);
    return (k >= 4'hC);
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Keypad-idle timer: counts 1 Hz ticks while enabled, saturating at
// TIMEOUT_SEC, and flags timeout once that count is reached.
module aclk_timeout_cnt #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic one_second,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_SEC);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step on a tick until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && one_second && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/aclk_ctrl_fsm.sv
// Keypad-entry controller: one shift strobe per digit press, load strobes
// to commit the entered time, display-select flags, and idle timeout.
module aclk_ctrl_fsm
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_second,
  input  logic [3:0] key,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a
);

  aclk_state_t state_q, state_d;
  logic        timeout;
  logic        cnt_en;
  logic        cnt_clr;

  // Next-state logic; key events are tested before timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (key == KEY_ALARM)    state_d = SHOW_ALARM;
        else if (is_digit(key))  state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (is_nokey(key))       state_d = KEY_ENTRY;
        else if (timeout)        state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (is_digit(key))         state_d = KEY_STORED;
        else if (key == KEY_ALARM) state_d = SET_ALARM_TIME;
        else if (key == KEY_TIME)  state_d = SET_CURRENT_TIME;
        else if (timeout)          state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (key != KEY_ALARM)    state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Clearing on the next state (not the current one) both resets the count on
  // entry to KEY_STORED and drops a tick that lands on an exit from the
  // waiting states.
  assign cnt_en  = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign cnt_clr = !((state_d == KEY_WAITED) || (state_d == KEY_ENTRY));

  aclk_timeout_cnt #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .one_second (one_second),
    .timeout    (timeout)
  );

  // Moore outputs decoded from the state register.
  assign shift         = (state_q == KEY_STORED);
  assign load_new_a    = (state_q == SET_ALARM_TIME);
  assign load_new_c    = (state_q == SET_CURRENT_TIME);
  assign show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                         (state_q == KEY_ENTRY);
  assign show_a        = (state_q == SHOW_ALARM);

endmodule

// File: tb/tb_aclk_ctrl_fsm.sv
// Directed bench for the keypad-entry controller. Outputs are compared as
// the vector {shift, load_new_a, load_new_c, show_new_time, show_a}.
module tb_aclk_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic       one_second;
  logic [3:0] key;
  logic       shift, load_new_a, load_new_c, show_new_time, show_a;

  int n_checks = 0;
  int n_errors = 0;
  int n_shift  = 0;
  int n_load_a = 0;
  int n_load_c = 0;

  aclk_ctrl_fsm #(
    .TIMEOUT_SEC(10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .one_second    (one_second),
    .key           (key),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .show_new_time (show_new_time),
    .show_a        (show_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters, sampled on the edge that ends each cycle.
  always @(posedge clk) begin
    if (shift === 1'b1)      n_shift++;
    if (load_new_a === 1'b1) n_load_a++;
    if (load_new_c === 1'b1) n_load_c++;
  end

  function automatic logic [4:0] outs();
    return {shift, load_new_a, load_new_c, show_new_time, show_a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge consume them, check the outputs.
  task automatic step(input logic [3:0] k, input logic t, input logic [4:0] exp, input string tag);
    key        = k;
    one_second = t;
    @(posedge clk);
    #1;
    one_second = 1'b0;
    check(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic do_reset();
    key        = 4'hF;
    one_second = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Enter a digit and move to KEY_ENTRY, then deliver n ticks every 4 cycles.
  task automatic to_entry_with_ticks(input int n, input string tag);
    step(4'd5, 1'b0, 5'b10010, {tag, "_stored"});
    step(4'hF, 1'b0, 5'b00010, {tag, "_waited"});
    step(4'hF, 1'b0, 5'b00010, {tag, "_entry"});
    for (int i = 0; i < n; i++) begin
      step(4'hF, 1'b0, 5'b00010, {tag, "_idle"});
      step(4'hF, 1'b0, 5'b00010, {tag, "_idle"});
      step(4'hF, 1'b0, 5'b00010, {tag, "_idle"});
      step(4'hF, 1'b1, 5'b00010, {tag, "_tick"});
    end
  endtask

  localparam logic [4:0] O_STORED = 5'b10010;
  localparam logic [4:0] O_ENTRY  = 5'b00010;
  localparam logic [4:0] O_IDLE   = 5'b00000;
  localparam logic [4:0] O_LOADA  = 5'b01000;
  localparam logic [4:0] O_LOADC  = 5'b00100;
  localparam logic [4:0] O_ALARM  = 5'b00001;

  initial begin
    int s0, a0, c0;
    key        = 4'hF;
    one_second = 1'b0;
    rst        = 1'b1;
    #2;
    check("reset_hold", 32'(outs()), 32'(O_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(4'hF, 1'b0, O_IDLE, "idle_after_reset");

    // Asynchronous reset while shift is high.
    step(4'd9, 1'b0, O_STORED, "pre_async_stored");
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outs", 32'(outs()), 32'(O_IDLE));
    do_reset();
    for (int i = 0; i < 5; i++) step(4'hF, 1'b0, O_IDLE, "idle_after_async");

    // Single press held 6 cycles.
    s0 = n_shift;
    step(4'd7, 1'b0, O_STORED, "single_shift");
    for (int i = 0; i < 5; i++) step(4'd7, 1'b0, O_ENTRY, "single_hold");
    step(4'hF, 1'b0, O_ENTRY, "single_release");
    step(4'hF, 1'b0, O_ENTRY, "single_entry");
    check("single_shift_count", 32'(n_shift - s0), 32'd1);

    // Full entry terminated with TIME.
    do_reset();
    s0 = n_shift; a0 = n_load_a; c0 = n_load_c;
    for (int d = 1; d <= 4; d++) begin
      step(4'(d), 1'b0, O_STORED, "full_c_shift");
      step(4'(d), 1'b0, O_ENTRY,  "full_c_hold");
      step(4'(d), 1'b0, O_ENTRY,  "full_c_hold");
      step(4'hF,  1'b0, O_ENTRY,  "full_c_gap");
      step(4'hF,  1'b0, O_ENTRY,  "full_c_gap");
    end
    step(4'hB, 1'b0, O_LOADC, "full_c_load");
    step(4'hB, 1'b0, O_IDLE,  "full_c_show_time");
    step(4'hB, 1'b0, O_IDLE,  "full_c_time_held");
    step(4'hF, 1'b0, O_IDLE,  "full_c_done");
    check("full_c_shifts", 32'(n_shift - s0), 32'd4);
    check("full_c_load_c", 32'(n_load_c - c0), 32'd1);
    check("full_c_load_a", 32'(n_load_a - a0), 32'd0);

    // Same entry terminated with ALARM; held ALARM then shows the alarm.
    s0 = n_shift; a0 = n_load_a; c0 = n_load_c;
    for (int d = 1; d <= 4; d++) begin
      step(4'(d), 1'b0, O_STORED, "full_a_shift");
      step(4'(d), 1'b0, O_ENTRY,  "full_a_hold");
      step(4'(d), 1'b0, O_ENTRY,  "full_a_hold");
      step(4'hF,  1'b0, O_ENTRY,  "full_a_gap");
      step(4'hF,  1'b0, O_ENTRY,  "full_a_gap");
    end
    step(4'hA, 1'b0, O_LOADA, "full_a_load");
    step(4'hA, 1'b0, O_IDLE,  "full_a_show_time");
    step(4'hA, 1'b0, O_ALARM, "full_a_held_alarm");
    step(4'hF, 1'b0, O_IDLE,  "full_a_done");
    check("full_a_shifts", 32'(n_shift - s0), 32'd4);
    check("full_a_load_a", 32'(n_load_a - a0), 32'd1);
    check("full_a_load_c", 32'(n_load_c - c0), 32'd0);

    // Timeout after the 10th tick; no load strobe.
    do_reset();
    a0 = n_load_a; c0 = n_load_c;
    to_entry_with_ticks(10, "to");
    step(4'hF, 1'b0, O_IDLE, "to_expired");
    step(4'hF, 1'b0, O_IDLE, "to_stays");
    check("to_no_load", 32'((n_load_a - a0) + (n_load_c - c0)), 32'd0);

    // Digit coinciding with the 10th tick wins; the count restarts.
    do_reset();
    to_entry_with_ticks(9, "tod");
    step(4'd3, 1'b1, O_STORED, "tod_digit_on_tick");
    step(4'hF, 1'b0, O_ENTRY,  "tod_waited");
    step(4'hF, 1'b0, O_ENTRY,  "tod_entry");
    step(4'hF, 1'b0, O_ENTRY,  "tod_count_cleared");

    // Digit in the cycle timeout is already flagged still wins.
    do_reset();
    to_entry_with_ticks(10, "tok");
    step(4'd6, 1'b0, O_STORED, "tok_digit_beats_timeout");
    step(4'hF, 1'b0, O_ENTRY,  "tok_waited");

    // TIME in SHOW_TIME does nothing; ALARM held 8 cycles shows the alarm.
    do_reset();
    s0 = n_shift;
    step(4'hB, 1'b0, O_IDLE, "time_in_show_time");
    for (int i = 0; i < 8; i++) step(4'hA, 1'b0, O_ALARM, "show_alarm_held");
    step(4'hF, 1'b0, O_IDLE, "show_alarm_release");
    step(4'hD, 1'b0, O_IDLE, "unused_code_idle");
    check("show_alarm_no_shift", 32'(n_shift - s0), 32'd0);

    // Reset in KEY_WAITED after two digits abandons the entry.
    do_reset();
    a0 = n_load_a; c0 = n_load_c;
    step(4'd1, 1'b0, O_STORED, "mid_d1");
    step(4'd1, 1'b0, O_ENTRY,  "mid_d1_wait");
    step(4'hF, 1'b0, O_ENTRY,  "mid_gap");
    step(4'd2, 1'b0, O_STORED, "mid_d2");
    step(4'd2, 1'b0, O_ENTRY,  "mid_d2_wait");
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_outs", 32'(outs()), 32'(O_IDLE));
    do_reset();
    step(4'hB, 1'b0, O_IDLE, "mid_time_after_reset");
    step(4'hF, 1'b0, O_IDLE, "mid_idle");
    step(4'hF, 1'b0, O_IDLE, "mid_idle");
    check("mid_no_load", 32'((n_load_a - a0) + (n_load_c - c0)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
